// File: rtl/mac_out_drain.sv
// Reader-side drain controller for the MAC output FIFO: pops Len words and streams them
// through a 2-entry skid stage. Optional OutParity port when MAC_OUT_DRAIN_PARITY_EN is defined.
module mac_out_drain #(
    parameter int DataWidth   = 32,
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4,
    parameter int LenWidth    = 8,
    parameter int Threshold   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Start,
    input  logic [LenWidth-1:0]    Len,
    input  logic                   Flush,
    input  logic [BufferSize-1:0]  ReadyM,
    input  logic [DataWidth-1:0]   DataOut2,
    output logic                   Pop2,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [DataWidth-1:0]   OutData,
    output logic                   Busy,
    output logic                   Done,
    output logic [LenWidth-1:0]    Remaining
`ifdef MAC_OUT_DRAIN_PARITY_EN
    ,
    output logic                   OutParity
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_STREAM, S_DRAIN, S_DONE} state_t;

    localparam logic [BufferWidth:0] THR_OCC = (BufferWidth + 1)'(Threshold);
    localparam logic [LenWidth-1:0]  THR_LEN = LenWidth'(Threshold);

    state_t                 state_q, state_d;
    logic [BufferWidth-1:0] head_q, head_d;
    logic [LenWidth-1:0]    pop_cnt_q, pop_cnt_d;
    logic [LenWidth-1:0]    len_q, len_d;
    logic [LenWidth-1:0]    rem_q, rem_d;
    logic                   busy_q, busy_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [DataWidth-1:0]   ent0_q, ent0_d, ent1_q, ent1_d;
    logic                   par0_q, par0_d, par1_q, par1_d;

    logic [BufferWidth:0]   occ;
    logic [LenWidth-1:0]    tail;
    logic                   avail, pop, xfer;

    always_comb begin
        occ = '0;
        for (int i = 0; i < BufferSize; i++) begin
            occ = occ + (BufferWidth + 1)'(ReadyM[i]);
        end
    end

    assign avail = ReadyM[head_q];
    assign tail  = len_q - pop_cnt_q;
    assign xfer  = (cnt_q != 2'd0) && OutReady;
    assign pop   = (state_q == S_STREAM) && avail && (cnt_q != 2'd2) && (pop_cnt_q < len_q);

    // Skid stage: entry 0 is always the oldest word; pop and transfer together only when one word is held.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        par0_d = par0_q;
        par1_d = par1_q;
        cnt_d  = cnt_q;
        unique case ({pop, xfer})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = DataOut2;
                    par0_d = ^DataOut2;
                end else begin
                    ent1_d = DataOut2;
                    par1_d = ^DataOut2;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                par0_d = par1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                ent0_d = DataOut2;
                par0_d = ^DataOut2;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        busy_d    = busy_q;
        head_d    = head_q + BufferWidth'(pop);
        pop_cnt_d = pop_cnt_q + LenWidth'(pop);
        rem_d     = rem_q - LenWidth'(xfer);
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    len_d     = Len;
                    rem_d     = Len;
                    pop_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = (Len == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // The tail term lets jobs shorter than the threshold start without waiting forever.
                if ((occ >= THR_OCC) || Flush || (tail < THR_LEN)) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pop_cnt_d == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((cnt_d == 2'd0) && (rem_d == '0)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            head_q    <= '0;
            pop_cnt_q <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= 2'd0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            par0_q    <= 1'b0;
            par1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            pop_cnt_q <= pop_cnt_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            par0_q    <= par0_d;
            par1_q    <= par1_d;
        end
    end

    assign Pop2      = pop;
    assign OutValid  = (cnt_q != 2'd0);
    assign OutData   = ent0_q;
    assign Busy      = busy_q;
    assign Done      = (state_q == S_DONE);
    assign Remaining = rem_q;

`ifdef MAC_OUT_DRAIN_PARITY_EN
    assign OutParity = par0_q;
`else
    logic unused_par;
    assign unused_par = par0_q ^ par1_q;
`endif

endmodule

// File: tb/tb_mac_out_drain.sv
// Bench for mac_out_drain: a behavioural FIFO feeds the DUT, a queue tracks words in push order.
// Table-driven first job plus hand-written sequences for threshold, wrap, stall, Len=0 and reset.
module tb_mac_out_drain;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, flush, out_ready;
    logic [7:0]  len;
    logic [3:0]  ready_m;
    logic [31:0] data_out2;
    logic        pop2, out_valid, busy, done;
    logic [31:0] out_data;
    logic [7:0]  remaining;
`ifdef MAC_OUT_DRAIN_PARITY_EN
    logic        out_parity;
`endif

    mac_out_drain dut (
        .clk(clk), .rst(rst), .Start(start), .Len(len), .Flush(flush),
        .ReadyM(ready_m), .DataOut2(data_out2), .Pop2(pop2), .OutValid(out_valid),
        .OutReady(out_ready), .OutData(out_data), .Busy(busy), .Done(done),
        .Remaining(remaining)
`ifdef MAC_OUT_DRAIN_PARITY_EN
        , .OutParity(out_parity)
`endif
    );

    logic [31:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic        push;
    logic [31:0] push_data;

    always @(posedge clk) begin
        if (!rst) begin
            ready_m <= 4'b0;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
        end else begin
            if (pop2) begin
                ready_m[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 2'd1;
            end
            if (push) begin
                mem[wr_ptr]     <= push_data;
                ready_m[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 2'd1;
            end
        end
    end
    assign data_out2 = mem[rd_ptr];

    logic [31:0] to_push[$];
    logic [31:0] exp_q[$];
    int nvec = 0, nerr = 0, pops = 0, dones = 0;
    logic        s_pop, s_ov, s_busy, s_done;
    logic [31:0] s_data;
    logic [7:0]  s_rem;

    typedef struct {
        logic        start;
        logic [7:0]  len;
        logic        pop;
        logic        ov;
        logic        chkd;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic [7:0]  rem;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1: apply a pending push, sample at negedge, return at next posedge+1.
    task automatic step();
        push = 1'b0;
        if (rst && to_push.size() != 0 && ready_m[wr_ptr] == 1'b0) begin
            push      = 1'b1;
            push_data = to_push.pop_front();
            exp_q.push_back(push_data);
        end
        @(negedge clk);
        s_pop  = pop2;
        s_ov   = out_valid;
        s_data = out_data;
        s_busy = busy;
        s_done = done;
        s_rem  = remaining;
        if (pop2) pops++;
        if (done) dones++;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL extra_word: got %h expected none", out_data);
            end else begin
                chk("stream_order", out_data, exp_q.pop_front());
            end
        end
`ifdef MAC_OUT_DRAIN_PARITY_EN
        if (out_valid) chk("parity", {31'b0, out_parity}, {31'b0, ^out_data});
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input string name, input int budget);
        logic got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            step();
            got = s_done;
        end
        chk({name, "_done_seen"}, {31'b0, got}, 32'd1);
        chk({name, "_rem_at_done"}, {24'b0, s_rem}, 32'd0);
    endtask

    task automatic finish_job(input string name, input int exp_pops);
        chk({name, "_pops"}, pops, exp_pops);
        chk({name, "_done_count"}, dones, 32'd1);
        chk({name, "_words_left"}, exp_q.size(), 32'd0);
        step();
        chk({name, "_busy_after"}, {31'b0, s_busy}, 32'd0);
        chk({name, "_done_after"}, {31'b0, s_done}, 32'd0);
    endtask

    task automatic begin_job(input logic [7:0] l);
        pops  = 0;
        dones = 0;
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    vec_t        tbl[9];
    logic [31:0] first_word;

    initial begin
        rst = 1'b0; start = 1'b0; len = 8'd0; flush = 1'b0; out_ready = 1'b1;
        push = 1'b0; push_data = 32'h0;
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_pop", {31'b0, s_pop}, 32'd0);
        chk("rst_valid", {31'b0, s_ov}, 32'd0);
        chk("rst_data", s_data, 32'd0);
        chk("rst_busy", {31'b0, s_busy}, 32'd0);
        chk("rst_done", {31'b0, s_done}, 32'd0);
        chk("rst_rem", {24'b0, s_rem}, 32'd0);

        // Job 1: four words preloaded, full-rate drain
        tbl[0] = '{1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 8'd4};
        tbl[2] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 8'd4};
        tbl[3] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 32'hA000_000A, 1'b1, 1'b0, 8'd4};
        tbl[4] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 32'hB000_000B, 1'b1, 1'b0, 8'd3};
        tbl[5] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 32'hC000_000C, 1'b1, 1'b0, 8'd2};
        tbl[6] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 32'hD000_000D, 1'b1, 1'b0, 8'd1};
        tbl[7] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 8'd0};
        tbl[8] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 8'd0};
        to_push = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D};
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 9; i++) begin
            start = tbl[i].start;
            len   = tbl[i].len;
            step();
            chk($sformatf("v%0d_pop", i), {31'b0, s_pop}, {31'b0, tbl[i].pop});
            chk($sformatf("v%0d_valid", i), {31'b0, s_ov}, {31'b0, tbl[i].ov});
            if (tbl[i].chkd) chk($sformatf("v%0d_data", i), s_data, tbl[i].data);
            chk($sformatf("v%0d_busy", i), {31'b0, s_busy}, {31'b0, tbl[i].busy});
            chk($sformatf("v%0d_done", i), {31'b0, s_done}, {31'b0, tbl[i].done});
            chk($sformatf("v%0d_rem", i), {24'b0, s_rem}, {24'b0, tbl[i].rem});
        end
        start = 1'b0;

        // Job 2: Len=3 with one word ready waits for the threshold
        to_push.push_back(32'h0000_0E01);
        step();
        begin_job(8'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("thr_wait_pop", {31'b0, s_pop}, 32'd0);
        end
        to_push.push_back(32'h0000_0E02);
        step();
        chk("thr_push_pop", {31'b0, s_pop}, 32'd0);
        step();
        chk("thr_decide_pop", {31'b0, s_pop}, 32'd0);
        step();
        chk("thr_start_pop", {31'b0, s_pop}, 32'd1);
        to_push.push_back(32'h0000_0E03);
        run_until_done("thr", 30);
        finish_job("thr", 3);

        // Job 3: Len=6 with continuous pushes, read head wraps
        for (int i = 0; i < 6; i++) to_push.push_back(32'h0600_0000 + i);
        begin_job(8'd6);
        run_until_done("wrap", 60);
        finish_job("wrap", 6);

        // Job 4: Flush bypasses the threshold with one word ready
        to_push.push_back(32'h0F00_0001);
        step();
        flush = 1'b1;
        begin_job(8'd3);
        step();
        step();
        chk("flush_pop", {31'b0, s_pop}, 32'd1);
        flush = 1'b0;
        to_push.push_back(32'h0F00_0002);
        to_push.push_back(32'h0F00_0003);
        run_until_done("flush", 40);
        finish_job("flush", 3);

        // Job 5: back-pressure with a full FIFO
        first_word = 32'h5500_0001;
        for (int i = 0; i < 4; i++) to_push.push_back(32'h5500_0001 + i);
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        begin_job(8'd6);
        for (int i = 0; i < 5; i++) begin
            step();
            if (s_ov) chk("stall_frozen", s_data, first_word);
        end
        chk("stall_pops", pops, 32'd2);
        chk("stall_pop_low", {31'b0, s_pop}, 32'd0);
        chk("stall_valid", {31'b0, s_ov}, 32'd1);
        out_ready = 1'b1;
        to_push.push_back(32'h5500_0005);
        to_push.push_back(32'h5500_0006);
        run_until_done("stall", 40);
        finish_job("stall", 6);

        // Job 6: Len=0
        begin_job(8'd0);
        step();
        chk("len0_busy", {31'b0, s_busy}, 32'd1);
        chk("len0_done", {31'b0, s_done}, 32'd1);
        step();
        chk("len0_busy_after", {31'b0, s_busy}, 32'd0);
        chk("len0_done_after", {31'b0, s_done}, 32'd0);
        chk("len0_pops", pops, 32'd0);

        // Job 7: reset mid-stream, then a fresh Len=2 job
        to_push.push_back(32'h7700_0001);
        to_push.push_back(32'h7700_0002);
        step();
        step();
        begin_job(8'd4);
        step();
        step();
        chk("mid_pop", {31'b0, s_pop}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_q.delete();
        to_push.delete();
        step();
        chk("mrst_pop", {31'b0, s_pop}, 32'd0);
        chk("mrst_valid", {31'b0, s_ov}, 32'd0);
        chk("mrst_data", s_data, 32'd0);
        chk("mrst_busy", {31'b0, s_busy}, 32'd0);
        chk("mrst_done", {31'b0, s_done}, 32'd0);
        chk("mrst_rem", {24'b0, s_rem}, 32'd0);
        to_push.push_back(32'h8800_0001);
        to_push.push_back(32'h8800_0002);
        begin_job(8'd2);
        run_until_done("post_rst", 30);
        finish_job("post_rst", 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
